fetch_cycle: RTL and testbench

Pipeline fetch stage and F-D buffer for the SimpleRISC 5-stage core. It owns the program counter, drives the instruction-memory address, and latches the fetched word into the F-D pipeline register that feeds the decode stage as pc_D/instruction_D. It honours the hazard unit's stall request and the execute stage's taken-branch redirect, and it keeps per-run fetch/stall/flush counters for debug.

---
 rtl/fetch_cycle.sv | 79 +++++++
 tb/tb_fetch_cycle.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_cycle.sv
// Fetch stage and F-D pipeline buffer: owns the PC, drives instruction memory,
// and applies load-use stalls and taken-branch redirects with debug counters.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h6800_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        add_stall,
    input  logic        isbranch_taken_E,
    input  logic [31:0] branch_pc_E,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_D,
    output logic [31:0] instruction_D,
    output logic        valid_D,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    typedef enum logic {BOOT, RUN} mode_t;

    mode_t       mode_q, mode_n;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        redirect;
    logic        hold;

    always_ff @(posedge clk) begin
        if (rst) mode_q <= BOOT;
        else     mode_q <= mode_n;
    end

    // In BOOT, E only holds the reset bubble, so its stall/redirect are ignored.
    always_comb begin
        mode_n   = RUN;
        redirect = 1'b0;
        hold     = 1'b0;
        if (mode_q == RUN) begin
            redirect = isbranch_taken_E;
            hold     = add_stall && !isbranch_taken_E;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f        <= RESET_PC;
            pc_d        <= 32'h0;
            instr_d     <= NOP_WORD;
            valid_d     <= 1'b0;
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
            flush_count <= 32'h0;
        end else if (redirect) begin
            pc_f        <= branch_pc_E;
            pc_d        <= 32'h0;
            instr_d     <= NOP_WORD;
            valid_d     <= 1'b0;
            flush_count <= flush_count + 32'd1;
        end else if (hold) begin
            stall_count <= stall_count + 32'd1;
        end else begin
            pc_d        <= pc_f;
            instr_d     <= imem_rdata;
            valid_d     <= 1'b1;
            pc_f        <= pc_f + 32'd4;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign imem_addr     = pc_f;
    assign pc_D          = pc_d;
    assign instruction_D = instr_d;
    assign valid_D       = valid_d;

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: two instances (default reset PC and a wrapping one)
// checked against a cycle-level reference model after every clock edge.
module tb_fetch_cycle;

    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        clk;
    logic        rst;
    logic        add_stall;
    logic        isbranch_taken_E;
    logic [31:0] branch_pc_E;
    logic [31:0] key;

    logic [31:0] imem_addr[2];
    logic [31:0] imem_rdata[2];
    logic [31:0] pc_D[2];
    logic [31:0] instruction_D[2];
    logic        valid_D[2];
    logic [31:0] fetch_count[2];
    logic [31:0] stall_count[2];
    logic [31:0] flush_count[2];

    int total = 0;
    int bad   = 0;

    // model state per instance
    logic [31:0] rpc[2];
    logic [31:0] m_pc[2], m_pcd[2], m_ins[2], m_f[2], m_s[2], m_fl[2];
    logic        m_v[2];
    int          since_rst[2];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_rdata[0] = imem_addr[0] ^ key;
    assign imem_rdata[1] = imem_addr[1] ^ key;

    fetch_cycle dut0 (
        .clk(clk), .rst(rst), .add_stall(add_stall),
        .isbranch_taken_E(isbranch_taken_E), .branch_pc_E(branch_pc_E),
        .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
        .pc_D(pc_D[0]), .instruction_D(instruction_D[0]), .valid_D(valid_D[0]),
        .fetch_count(fetch_count[0]), .stall_count(stall_count[0]),
        .flush_count(flush_count[0])
    );

    fetch_cycle #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .add_stall(add_stall),
        .isbranch_taken_E(isbranch_taken_E), .branch_pc_E(branch_pc_E),
        .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
        .pc_D(pc_D[1]), .instruction_D(instruction_D[1]), .valid_D(valid_D[1]),
        .fetch_count(fetch_count[1]), .stall_count(stall_count[1]),
        .flush_count(flush_count[1])
    );

    // reference model: one clock edge of fetch behaviour
    task automatic model_edge(input int i);
        bit boot;
        if (rst) begin
            m_pc[i] = rpc[i]; m_pcd[i] = 0; m_ins[i] = NOP; m_v[i] = 0;
            m_f[i] = 0; m_s[i] = 0; m_fl[i] = 0; since_rst[i] = 0;
        end else begin
            boot = (since_rst[i] == 0);
            if (!boot && isbranch_taken_E) begin
                m_pc[i] = branch_pc_E; m_pcd[i] = 0; m_ins[i] = NOP; m_v[i] = 0;
                m_fl[i] = m_fl[i] + 1;
            end else if (!boot && add_stall) begin
                m_s[i] = m_s[i] + 1;
            end else begin
                m_pcd[i] = m_pc[i]; m_ins[i] = m_pc[i] ^ key; m_v[i] = 1;
                m_pc[i] = m_pc[i] + 4; m_f[i] = m_f[i] + 1;
            end
            since_rst[i] = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("imem_addr[%0d]", i), imem_addr[i], m_pc[i]);
            check($sformatf("pc_D[%0d]", i), pc_D[i], m_pcd[i]);
            check($sformatf("instruction_D[%0d]", i), instruction_D[i], m_ins[i]);
            check($sformatf("valid_D[%0d]", i), {31'b0, valid_D[i]}, {31'b0, m_v[i]});
            check($sformatf("fetch_count[%0d]", i), fetch_count[i], m_f[i]);
            check($sformatf("stall_count[%0d]", i), stall_count[i], m_s[i]);
            check($sformatf("flush_count[%0d]", i), flush_count[i], m_fl[i]);
        end
    endtask

    // driver: apply inputs, clock one edge, update model, check after edge
    task automatic step(input logic r, input logic st, input logic br, input logic [31:0] bpc);
        rst = r; add_stall = st; isbranch_taken_E = br; branch_pc_E = bpc;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    initial begin
        rpc[0] = 32'h0; rpc[1] = 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) since_rst[i] = 0;
        key = 32'h0;
        rst = 1'b1; add_stall = 1'b0; isbranch_taken_E = 1'b0; branch_pc_E = 32'h0;
        @(negedge clk);

        // reset values
        step(1, 0, 0, 0);
        check("rst imem_addr", imem_addr[0], 32'h0);
        check("rst instruction_D", instruction_D[0], NOP);
        check("rst valid_D", {31'b0, valid_D[0]}, 32'h0);

        // free run, memory word = address; instance 1 wraps to 0
        step(0, 0, 0, 0);
        check("wrap imem_addr", imem_addr[1], 32'h0);
        check("wrap pc_D", pc_D[1], 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("run pc_D", pc_D[0], 32'h8);
        check("run instruction_D", instruction_D[0], 32'h8);
        check("run fetch_count", fetch_count[0], 32'd3);
        check("run imem_addr", imem_addr[0], 32'hC);

        // stall while pc_D=4
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("stall1 pc_D", pc_D[0], 32'h4);
        check("stall1 imem_addr", imem_addr[0], 32'h8);
        step(0, 1, 0, 0);
        check("stall2 pc_D", pc_D[0], 32'h4);
        check("stall2 imem_addr", imem_addr[0], 32'h8);
        check("stall_count", stall_count[0], 32'd2);
        step(0, 0, 0, 0);
        check("resume pc_D", pc_D[0], 32'h8);

        // redirect while imem_addr=0x10
        step(0, 0, 0, 0);
        check("pre-branch imem_addr", imem_addr[0], 32'h10);
        step(0, 0, 1, 32'h40);
        check("branch imem_addr", imem_addr[0], 32'h40);
        check("branch instruction_D", instruction_D[0], NOP);
        check("branch valid_D", {31'b0, valid_D[0]}, 32'h0);
        check("branch flush_count", flush_count[0], 32'd1);
        step(0, 0, 0, 0);
        check("target pc_D", pc_D[0], 32'h40);

        // simultaneous stall and redirect
        step(0, 1, 1, 32'h103);
        check("both imem_addr", imem_addr[0], 32'h103);
        check("both stall_count", stall_count[0], 32'd2);
        check("both flush_count", flush_count[0], 32'd2);

        // BOOT ignores stall and redirect
        step(1, 0, 0, 0);
        step(0, 1, 1, 32'h80);
        check("boot pc_D", pc_D[0], 32'h0);
        check("boot valid_D", {31'b0, valid_D[0]}, 32'h1);
        check("boot imem_addr", imem_addr[0], 32'h4);

        // reset mid-stall
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 1, 32'h200);
        check("midrst pc_D", pc_D[0], 32'h0);
        check("midrst imem_addr", imem_addr[1], 32'hFFFF_FFFC);
        check("midrst stall_count", stall_count[0], 32'h0);

        // randomized run against the model
        key = $urandom;
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0),
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
